// File: rtl/ahb_gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO peripheral: register offsets,
// HTRANS encodings and the register-index decode.
package ahb_gpio_pkg;

  localparam logic [7:0] OFF_DATA  = 8'h00;
  localparam logic [7:0] OFF_DIR   = 8'h04;
  localparam logic [7:0] OFF_SET   = 8'h08;
  localparam logic [7:0] OFF_CLR   = 8'h0C;
  localparam logic [7:0] OFF_IE    = 8'h10;
  localparam logic [7:0] OFF_ITYPE = 8'h14;
  localparam logic [7:0] OFF_IPOL  = 8'h18;
  localparam logic [7:0] OFF_ISTAT = 8'h1C;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [3:0] {
    REG_DATA,
    REG_DIR,
    REG_SET,
    REG_CLR,
    REG_IE,
    REG_ITYPE,
    REG_IPOL,
    REG_ISTAT,
    REG_NONE
  } reg_idx_e;

  // Word-aligned decode of the low address byte; byte lanes are ignored.
  function automatic reg_idx_e decode_reg(input logic [7:0] addr);
    logic [7:0] word_addr;
    word_addr = {addr[7:2], 2'b00};
    case (word_addr)
      OFF_DATA:  return REG_DATA;
      OFF_DIR:   return REG_DIR;
      OFF_SET:   return REG_SET;
      OFF_CLR:   return REG_CLR;
      OFF_IE:    return REG_IE;
      OFF_ITYPE: return REG_ITYPE;
      OFF_IPOL:  return REG_IPOL;
      OFF_ISTAT: return REG_ISTAT;
      default:   return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_irq_detect.sv
// Input synchroniser and per-bit interrupt event detection (edge or level,
// selectable polarity).
module gpio_irq_detect #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [WIDTH-1:0] GPIOIN,
  input  logic [WIDTH-1:0] ITYPE,
  input  logic [WIDTH-1:0] IPOL,
  output logic [WIDTH-1:0] evt,
  output logic [WIDTH-1:0] sync_in
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_prev;
  logic [WIDTH-1:0] pol_match;

  // Two-flop synchroniser plus one-cycle history for edge detection.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      meta_q    <= '0;
      sync_in   <= '0;
      sync_prev <= '0;
    end else begin
      meta_q    <= GPIOIN;
      sync_in   <= meta_q;
      sync_prev <= sync_in;
    end
  end

  // Edge bits fire on a change into the active polarity; level bits fire
  // every cycle the pin sits at the active polarity.
  always_comb begin
    pol_match = ~(sync_in ^ IPOL);
    evt       = (ITYPE & (sync_in ^ sync_prev) & pol_match) | (~ITYPE & pol_match);
  end

endmodule

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO peripheral with per-bit direction, atomic set/clear,
// and edge/level interrupts combined onto a single registered IRQ.
module ahb_gpio_irq
  import ahb_gpio_pkg::*;
#(
  parameter int unsigned     WIDTH    = 16,
  parameter logic [WIDTH-1:0] DOUT_RST = '0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH-1:0] GPIOIN,
  output logic [WIDTH-1:0] GPIOOUT,
  output logic [WIDTH-1:0] GPIOEN,
  output logic             IRQ
);

  logic             xfer_valid;
  logic             dp_valid;
  logic             dp_write;
  reg_idx_e         dp_reg;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] istat_clr;

  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] ie_q;
  logic [WIDTH-1:0] itype_q;
  logic [WIDTH-1:0] ipol_q;
  logic [WIDTH-1:0] istat_q;
  logic             irq_q;

  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] sync_in;
  logic             unused_ok;

  assign unused_ok = &{1'b0, HADDR[31:8], HWDATA};

  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign xfer_valid = HSEL & HREADY & (HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign wr_en      = dp_valid & dp_write;
  assign rd_en      = dp_valid & ~dp_write & ~HRESET;
  assign wdata      = HWDATA[WIDTH-1:0];
  assign istat_clr  = (wr_en && dp_reg == REG_ISTAT) ? wdata : '0;

  assign GPIOOUT = dout_q;
  assign GPIOEN  = dir_q;
  assign IRQ     = irq_q;

  gpio_irq_detect #(
    .WIDTH(WIDTH)
  ) u_detect (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .GPIOIN  (GPIOIN),
    .ITYPE   (itype_q),
    .IPOL    (ipol_q),
    .evt     (evt),
    .sync_in (sync_in)
  );

  // Address-phase capture: the decoded register index travels to the data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_reg   <= REG_NONE;
    end else begin
      dp_valid <= xfer_valid;
      if (xfer_valid) begin
        dp_write <= HWRITE;
        dp_reg   <= decode_reg(HADDR[7:0]);
      end
    end
  end

  // Data-phase writes to the control registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dout_q  <= DOUT_RST;
      dir_q   <= '0;
      ie_q    <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
    end else if (wr_en) begin
      case (dp_reg)
        REG_DATA:  dout_q  <= wdata;
        REG_DIR:   dir_q   <= wdata;
        REG_SET:   dout_q  <= dout_q | wdata;
        REG_CLR:   dout_q  <= dout_q & ~wdata;
        REG_IE:    ie_q    <= wdata;
        REG_ITYPE: itype_q <= wdata;
        REG_IPOL:  ipol_q  <= wdata;
        default:   ;
      endcase
    end
  end

  // Status latch: a detection in the same cycle as a W1C keeps the bit set.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      istat_q <= '0;
    end else begin
      istat_q <= (istat_q & ~istat_clr) | evt;
    end
  end

  // Registered combined interrupt request.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(istat_q & ie_q);
    end
  end

  // Read mux; bits above WIDTH are zero.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (dp_reg)
        REG_DATA:  rdata = (dir_q & dout_q) | (~dir_q & sync_in);
        REG_DIR:   rdata = dir_q;
        REG_IE:    rdata = ie_q;
        REG_ITYPE: rdata = itype_q;
        REG_IPOL:  rdata = ipol_q;
        REG_ISTAT: rdata = istat_q;
        default:   rdata = '0;
      endcase
    end
    HRDATA = '0;
    HRDATA[WIDTH-1:0] = rdata;
  end

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Directed testbench for ahb_gpio_irq: a 16-bit and an 8-bit instance share
// the bus inputs, so every transfer reaches both.
module tb_ahb_gpio_irq;
  import ahb_gpio_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT, HREADYOUT8;
  logic        HRESP, HRESP8;
  logic [31:0] HRDATA, HRDATA8;
  logic [15:0] gpio_in;
  logic [15:0] GPIOOUT, GPIOEN;
  logic [7:0]  GPIOOUT8, GPIOEN8;
  logic        IRQ, IRQ8;

  int tests = 0;
  int fails = 0;

  always #5 HCLK = ~HCLK;

  ahb_gpio_irq #(.WIDTH(16), .DOUT_RST(16'h0000)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .GPIOIN(gpio_in), .GPIOOUT(GPIOOUT),
    .GPIOEN(GPIOEN), .IRQ(IRQ)
  );

  ahb_gpio_irq #(.WIDTH(8), .DOUT_RST(8'h5A)) dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT8),
    .HRESP(HRESP8), .HRDATA(HRDATA8), .GPIOIN(gpio_in[7:0]), .GPIOOUT(GPIOOUT8),
    .GPIOEN(GPIOEN8), .IRQ(IRQ8)
  );

  // All tasks start and end 1 ns after a rising edge.
  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d, output logic [31:0] d8);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    d  = HRDATA;
    d8 = HRDATA8;
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    logic [7:0]  offs [9];
    logic [31:0] exp  [9];
    logic [31:0] d, d8;
    offs = '{OFF_DATA, OFF_DIR, OFF_SET, OFF_CLR, OFF_IE, OFF_ITYPE, OFF_IPOL, OFF_ISTAT, 8'h20};
    // Reset leaves every bit in level-low mode, so idle-low pins mark ISTAT at once.
    exp  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000FFFF, 32'h0};
    for (int i = 0; i < 9; i++) begin
      ahb_read(offs[i], d, d8);
      tests++;
      if (d !== exp[i]) begin
        fails++; $display("FAIL reset_read[%h]: got %h expected %h", offs[i], d, exp[i]);
      end
      tests++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
        fails++; $display("FAIL reset_ready[%h]: got %b/%b expected 1/0", offs[i], HREADYOUT, HRESP);
      end
    end
    tests++;
    if (IRQ !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
    tests++;
    if (GPIOOUT8 !== 8'h5A) begin fails++; $display("FAIL reset_dout8: got %h expected 5a", GPIOOUT8); end
  endtask

  task automatic test_regs();
    logic [31:0] d, d8;
    ahb_write(OFF_DIR, 32'h0000_00FF);
    ahb_write(OFF_DATA, 32'h0000_1234);
    tests++;
    if (GPIOOUT !== 16'h1234) begin fails++; $display("FAIL data_wr: got %h expected 1234", GPIOOUT); end
    tests++;
    if (GPIOEN !== 16'h00FF) begin fails++; $display("FAIL dir_wr: got %h expected 00ff", GPIOEN); end
    ahb_write(OFF_SET, 32'h0000_0F00);
    ahb_write(OFF_CLR, 32'h0000_0004);
    tests++;
    if (GPIOOUT !== 16'h1F30) begin fails++; $display("FAIL set_clr: got %h expected 1f30", GPIOOUT); end
    ahb_read(OFF_DIR, d, d8);
    tests++;
    if (d !== 32'h0000_00FF) begin fails++; $display("FAIL dir_rd: got %h expected 000000ff", d); end
    ahb_read(OFF_SET, d, d8);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL set_rd: got %h expected 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = {24'h0, OFF_DATA};
    @(posedge HCLK); #1;
    HWDATA = 32'h0000_5A5A; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    d = HRDATA;
    tests++;
    if (d !== 32'h0000_005A) begin fails++; $display("FAIL b2b_read: got %h expected 0000005a", d); end
    tests++;
    if (GPIOOUT !== 16'h5A5A) begin fails++; $display("FAIL b2b_dout: got %h expected 5a5a", GPIOOUT); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_irq_edge();
    logic [31:0] d, d8;
    ahb_write(OFF_ITYPE, 32'h0000_FFFF);
    ahb_write(OFF_IPOL,  32'h0000_0008);
    ahb_write(OFF_ISTAT, 32'h0000_FFFF);
    ahb_write(OFF_IE,    32'h0000_0008);
    ahb_read(OFF_ISTAT, d, d8);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL istat_pre: got %h expected 0", d); end
    gpio_in[3] = 1'b1;                        // stable before edge k
    @(posedge HCLK); #1;                      // k
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = {24'h0, OFF_ISTAT};
    @(posedge HCLK); #1;                      // k+1
    tests++;
    if (HRDATA !== 32'h0) begin fails++; $display("FAIL istat_k1: got %h expected 0", HRDATA); end
    @(posedge HCLK); #1;                      // k+2
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    tests++;
    if (HRDATA !== 32'h0000_0008) begin fails++; $display("FAIL istat_k2: got %h expected 00000008", HRDATA); end
    tests++;
    if (IRQ !== 1'b0) begin fails++; $display("FAIL irq_k2: got %b expected 0", IRQ); end
    @(posedge HCLK); #1;                      // k+3
    tests++;
    if (IRQ !== 1'b1) begin fails++; $display("FAIL irq_k3: got %b expected 1", IRQ); end
    ahb_write(OFF_ISTAT, 32'h0000_0008);
    tests++;
    if (IRQ !== 1'b1) begin fails++; $display("FAIL irq_clr_edge: got %b expected 1", IRQ); end
    @(posedge HCLK); #1;
    tests++;
    if (IRQ !== 1'b0) begin fails++; $display("FAIL irq_clr_next: got %b expected 0", IRQ); end
    gpio_in[3] = 1'b0;
    repeat (4) @(posedge HCLK); #1;
    ahb_read(OFF_ISTAT, d, d8);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL falling_ignored: got %h expected 0", d); end
  endtask

  task automatic test_level_w1c();
    logic [31:0] d, d8;
    ahb_write(OFF_ITYPE, 32'h0000_FFDF);     // bit 5 level, low-active, pin low
    repeat (2) @(posedge HCLK); #1;
    ahb_write(OFF_ISTAT, 32'h0000_0020);
    ahb_read(OFF_ISTAT, d, d8);
    tests++;
    if (d !== 32'h0000_0020) begin fails++; $display("FAIL level_reset: got %h expected 00000020", d); end
    gpio_in[5] = 1'b1;
    repeat (3) @(posedge HCLK); #1;
    ahb_write(OFF_ISTAT, 32'h0000_0020);
    ahb_read(OFF_ISTAT, d, d8);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL level_released: got %h expected 0", d); end
    // Rising bit-3 edge lands in ISTAT on the same edge that commits the W1C.
    gpio_in[3] = 1'b1;
    @(posedge HCLK); #1;
    ahb_write(OFF_ISTAT, 32'h0000_0008);
    ahb_read(OFF_ISTAT, d, d8);
    tests++;
    if (d !== 32'h0000_0008) begin fails++; $display("FAIL set_wins: got %h expected 00000008", d); end
    ahb_write(OFF_ISTAT, 32'h0000_0008);
  endtask

  task automatic test_ie_mask();
    logic [31:0] d, d8;
    ahb_write(OFF_IE,    32'h0);
    ahb_write(OFF_ITYPE, 32'h0000_FFFF);
    ahb_write(OFF_IPOL,  32'h0000_0081);
    ahb_write(OFF_ISTAT, 32'h0000_FFFF);
    gpio_in[0] = 1'b1;
    gpio_in[7] = 1'b1;
    repeat (4) @(posedge HCLK); #1;
    ahb_read(OFF_ISTAT, d, d8);
    tests++;
    if (d !== 32'h0000_0081) begin fails++; $display("FAIL masked_istat: got %h expected 00000081", d); end
    tests++;
    if (IRQ !== 1'b0) begin fails++; $display("FAIL masked_irq: got %b expected 0", IRQ); end
    ahb_write(OFF_IE, 32'h0000_0080);
    tests++;
    if (IRQ !== 1'b0) begin fails++; $display("FAIL ie_commit_irq: got %b expected 0", IRQ); end
    @(posedge HCLK); #1;
    tests++;
    if (IRQ !== 1'b1) begin fails++; $display("FAIL ie_next_irq: got %b expected 1", IRQ); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, d8;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = {24'h0, OFF_DIR};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = 32'h0000_FFFF;
    HRESET = 1'b1;
    tests++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      fails++; $display("FAIL ready_in_reset: got %b/%b expected 1/0", HREADYOUT, HRESP);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    tests++;
    if (GPIOEN !== 16'h0) begin fails++; $display("FAIL mid_reset_dir: got %h expected 0000", GPIOEN); end
    tests++;
    if (IRQ !== 1'b0) begin fails++; $display("FAIL mid_reset_irq: got %b expected 0", IRQ); end
    tests++;
    if (GPIOOUT !== 16'h0 || GPIOOUT8 !== 8'h5A) begin
      fails++; $display("FAIL mid_reset_dout: got %h/%h expected 0000/5a", GPIOOUT, GPIOOUT8);
    end
    ahb_read(OFF_DIR, d, d8);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL mid_reset_dir_rd: got %h expected 0", d); end
  endtask

  task automatic test_width8();
    logic [31:0] d, d8;
    ahb_write(OFF_DIR,  32'h0000_FFFF);
    ahb_write(OFF_DATA, 32'h0000_FFFF);
    ahb_read(OFF_DATA, d, d8);
    tests++;
    if (d8 !== 32'h0000_00FF) begin fails++; $display("FAIL w8_data: got %h expected 000000ff", d8); end
    tests++;
    if (d !== 32'h0000_FFFF) begin fails++; $display("FAIL w16_data: got %h expected 0000ffff", d); end
    tests++;
    if (GPIOOUT8 !== 8'hFF) begin fails++; $display("FAIL w8_dout: got %h expected ff", GPIOOUT8); end
    ahb_read(OFF_DIR, d, d8);
    tests++;
    if (d8 !== 32'h0000_00FF) begin fails++; $display("FAIL w8_dir: got %h expected 000000ff", d8); end
    ahb_read(8'h20, d, d8);
    tests++;
    if (d !== 32'h0 || d8 !== 32'h0) begin fails++; $display("FAIL unmapped: got %h/%h expected 0/0", d, d8); end
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HWDATA = '0; HREADY = 1'b1; gpio_in = '0;
    repeat (3) @(posedge HCLK); #1;
    HRESET = 1'b0;
    test_reset();
    test_regs();
    test_back_to_back();
    test_irq_edge();
    test_level_w1c();
    test_ie_mask();
    test_reset_mid();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
